mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_MASTER, default 3, number of requesters (0 = dcache uncached, 1 = dcache refill, 2 = icache refill).
REQ-002 The block SHALL have parameter LEN_WIDTH, default 4, width of burst length field (beats minus one).
REQ-003 The block SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have m_req  input  N_MASTER  per-requester transaction request, held until grant.
REQ-006 The block SHALL have m_we  input  N_MASTER  per-requester write flag (1 = write burst, 0 = read burst).
REQ-007 The block SHALL have m_addr  input  N_MASTER x 32  per-requester physical start address.
REQ-008 The block SHALL have m_len  input  N_MASTER x LEN_WIDTH  per-requester beats minus one.
REQ-009 The block SHALL have m_wdata / m_wvalid  input  N_MASTER x 32 / N_MASTER  per-requester write beat.
REQ-010 The block SHALL have m_grant  output  N_MASTER  one-hot, one-cycle pulse when the request is accepted.
REQ-011 The block SHALL have m_wready / m_rvalid / m_done  output  N_MASTER each  write-beat accept, read-beat valid, final-beat pulse.
REQ-012 The block SHALL have m_rdata  output  32  read data, broadcast to all requesters.
REQ-013 The block SHALL have mem_req / mem_we / mem_addr / mem_len  output  1/1/32/LEN_WIDTH  downstream address phase.
REQ-014 The block SHALL have mem_ack  input  1  downstream accepts address phase.
REQ-015 The block SHALL have mem_wdata / mem_wvalid  output  32/1 and mem_wready  input  1  downstream write beat.
REQ-016 The block SHALL have mem_rdata / mem_rvalid / mem_rlast  input  32/1/1  downstream read beat.
REQ-017 The block SHALL have len_err  output  1  sticky flag: mem_rlast disagrees with beat counter.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, WDATA, RDATA.
REQ-019 In IDLE with any m_req high, the block SHALL pick a winner round-robin (priority starts after last winner), latch index/we/addr/len, pulse m_grant next cycle, enter ADDR.
REQ-020 In ADDR mem_req SHALL be 1 with latched we/addr/len; on mem_ack go to WDATA if we else RDATA; mem_req SHALL drop the cycle after ack.
REQ-021 In WDATA mem_wdata/mem_wvalid SHALL mirror the owner's m_wdata/m_wvalid combinationally and m_wready[owner] SHALL equal mem_wready; other requesters see 0.
REQ-022 Beat counter SHALL clear on entering WDATA/RDATA and increment on each wvalid&wready or rvalid beat.
REQ-023 Write burst SHALL end on the handshake with counter == latched len: m_done[owner] pulses that cycle, FSM returns to IDLE.
REQ-024 In RDATA m_rvalid[owner] SHALL equal mem_rvalid; burst ends on mem_rvalid&mem_rlast, m_done[owner] pulses same cycle, FSM to IDLE.
REQ-025 If mem_rlast arrives with counter != len, or counter reaches len without rlast, len_err SHALL set; burst ends only on rlast.
REQ-026 Earliest re-arbitration SHALL be the cycle after m_done (IDLE for one cycle between bursts); throughput loss accepted.
REQ-027 A requester dropping m_req after grant SHALL NOT abort its burst; m_req changes of non-owners are ignored until IDLE.
REQ-028 Len = 0 SHALL be a single-beat burst; len = 2^LEN_WIDTH-1 SHALL complete without counter wrap error.

Reset
REQ-029 On rst the FSM SHALL go to IDLE, RR pointer so requester 0 has top priority, counter 0, len_err 0, all outputs 0, even mid-burst.

Structure
REQ-030 The state enum and the mem request struct (we, addr, len) SHALL live in the shared cpu_defs package.
REQ-031 The round-robin picker SHALL be a sub-module rr_picker (request vector + pointer in, one-hot winner out).

Verification
REQ-032 m_req=3'b111, all reads len=7 -> grants in order 0,1,2; each sees 8 m_rvalid beats and one m_done.
REQ-033 Req 1 write len=3 addr=0x1fc0_0040, mem_wready toggling 1,0,1,0 -> exactly 4 mem_wvalid&wready beats, m_done[1] on 4th.
REQ-034 Req 0 held continuously plus req 2 arriving during req 0 burst -> req 2 granted next, not req 0 again.
REQ-035 Read len=3, mem_rlast on beat 2 -> len_err=1, burst ends after beat 2, FSM IDLE.
REQ-036 rst asserted in RDATA beat 3 -> next cycle all outputs 0, FSM IDLE, next request to 0 granted first.
REQ-037 mem_ack delayed 5 cycles -> mem_req stable with latched addr for all 5 cycles, no beat forwarded.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-side definitions: arbiter FSM states and the latched downstream command.
package cpu_defs;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W_MAX = 8;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} arb_state_t;

    // len is stored zero-extended so one struct serves every LEN_WIDTH up to LEN_W_MAX
    typedef struct packed {
        logic                 we;
        logic [ADDR_W-1:0]    addr;
        logic [LEN_W_MAX-1:0] len;
    } mem_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and downstream-memory-side buses of the memory arbiter.
interface mem_req_if #(parameter int N_MASTER = 3, parameter int LEN_WIDTH = 4);
    logic [N_MASTER-1:0]                m_req, m_we, m_wvalid;
    logic [N_MASTER-1:0][31:0]          m_addr, m_wdata;
    logic [N_MASTER-1:0][LEN_WIDTH-1:0] m_len;
    logic [N_MASTER-1:0]                m_grant, m_wready, m_rvalid, m_done;
    logic [31:0]                        m_rdata;

    modport master (output m_req, m_we, m_addr, m_len, m_wdata, m_wvalid,
                    input  m_grant, m_wready, m_rvalid, m_done, m_rdata);
    modport slave  (input  m_req, m_we, m_addr, m_len, m_wdata, m_wvalid,
                    output m_grant, m_wready, m_rvalid, m_done, m_rdata);
endinterface

interface mem_bus_if #(parameter int LEN_WIDTH = 4);
    logic                 mem_req, mem_we, mem_ack;
    logic [31:0]          mem_addr, mem_wdata, mem_rdata;
    logic [LEN_WIDTH-1:0] mem_len;
    logic                 mem_wvalid, mem_wready, mem_rvalid, mem_rlast;

    modport master (output mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid,
                    input  mem_ack, mem_wready, mem_rdata, mem_rvalid, mem_rlast);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wvalid,
                    output mem_ack, mem_wready, mem_rdata, mem_rvalid, mem_rlast);
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: ptr names the requester with top priority this round.
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PTR_W'((int'(ptr) + k) % N)]) begin
                gnt = '0;
                gnt[PTR_W'((int'(ptr) + k) % N)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter: N requesters share one downstream memory port, one burst at a time.
module mem_arbiter
    import cpu_defs::*;
#(
    parameter int N_MASTER  = 3,
    parameter int LEN_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    mem_req_if.slave   cpu,
    mem_bus_if.master  mem,
    output logic       len_err
);
    localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_t           state;
    mem_cmd_t             cmd;
    logic [PTR_W-1:0]     ptr, owner, pick_idx;
    logic [N_MASTER-1:0]  pick, grant_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 last_cnt, wbeat, rbeat;

    rr_picker #(.N(N_MASTER), .PTR_W(PTR_W)) u_rr (
        .req (cpu.m_req),
        .ptr (ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_MASTER; i++)
            if (pick[i]) pick_idx = PTR_W'(i);
    end

    assign last_cnt = (LEN_W_MAX'(cnt) == cmd.len);
    assign wbeat    = (state == WDATA) && cpu.m_wvalid[owner] && mem.mem_wready;
    assign rbeat    = (state == RDATA) && mem.mem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cmd     <= '0;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            grant_q <= '0;
            case (state)
                IDLE: if (|cpu.m_req) begin
                    owner   <= pick_idx;
                    grant_q <= pick;
                    ptr     <= (pick_idx == PTR_W'(N_MASTER - 1)) ? '0 : pick_idx + 1'b1;
                    cmd     <= '{we:   cpu.m_we[pick_idx],
                                 addr: cpu.m_addr[pick_idx],
                                 len:  LEN_W_MAX'(cpu.m_len[pick_idx])};
                    state   <= ADDR;
                end
                ADDR: if (mem.mem_ack) begin
                    cnt   <= '0;
                    state <= cmd.we ? WDATA : RDATA;
                end
                WDATA: if (wbeat) begin
                    cnt <= cnt + 1'b1;
                    if (last_cnt) state <= IDLE;
                end
                RDATA: if (rbeat) begin
                    // downstream owns burst termination; a length disagreement is only flagged
                    if (mem.mem_rlast != last_cnt) len_err <= 1'b1;
                    if (mem.mem_rlast)  state <= IDLE;
                    else if (!last_cnt) cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu.m_grant    = grant_q;
        cpu.m_wready   = '0;
        cpu.m_rvalid   = '0;
        cpu.m_done     = '0;
        cpu.m_rdata    = (state == RDATA) ? mem.mem_rdata : '0;
        mem.mem_req    = (state == ADDR);
        mem.mem_we     = (state == ADDR) && cmd.we;
        mem.mem_addr   = (state == ADDR) ? cmd.addr : '0;
        mem.mem_len    = (state == ADDR) ? cmd.len[LEN_WIDTH-1:0] : '0;
        mem.mem_wvalid = (state == WDATA) && cpu.m_wvalid[owner];
        mem.mem_wdata  = (state == WDATA) ? cpu.m_wdata[owner] : '0;
        if (state == WDATA) begin
            cpu.m_wready[owner] = mem.mem_wready;
            cpu.m_done[owner]   = wbeat && last_cnt;
        end
        if (state == RDATA) begin
            cpu.m_rvalid[owner] = mem.mem_rvalid;
            cpu.m_done[owner]   = rbeat && mem.mem_rlast;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus events are queued at stimulus time, a monitor pops them.
module tb_mem_arbiter;
    import cpu_defs::*;

    localparam int EV_GNT = 0, EV_CMD = 1, EV_RD = 2, EV_WR = 3, EV_DONE = 4;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic len_err;

    mem_req_if #(.N_MASTER(3), .LEN_WIDTH(4)) cpu();
    mem_bus_if #(.LEN_WIDTH(4))               mem();

    mem_arbiter #(.N_MASTER(3), .LEN_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (cpu),
        .mem     (mem),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    ev_t  exp_q[$];
    int   nvec = 0, nfail = 0;
    int   ack_delay = 0, rlast_at = -1;
    bit   wr_toggle = 1'b0;
    bit   auto_drop[3] = '{1'b1, 1'b1, 1'b1};
    int   wbeat[3] = '{0, 0, 0};

    function automatic logic [31:0] wd(input int i, input int b);
        return 32'hA000_0000 + 32'(i << 8) + 32'(b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input int idx, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    // grant, address phase, nbeats data beats, and optionally the done pulse
    task automatic push_burst(input int i, input bit we, input logic [31:0] addr,
                              input int len, input int nbeats, input bit done);
        push(EV_GNT, 1 << i, 32'h0);
        push(EV_CMD, int'(we) * 256 + len, addr);
        for (int b = 0; b < nbeats; b++) begin
            if (we) push(EV_WR, 1 << i, wd(i, b));
            else    push(EV_RD, 1 << i, addr + 32'(4 * b));
        end
        if (done) push(EV_DONE, 1 << i, 32'h0);
    endtask

    task automatic check_ev(input int kind, input int idx, input logic [31:0] data, input string nm);
        ev_t e;
        nvec++;
        if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL %s: unexpected event idx=%0d data=%h, expected none", nm, idx, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.data !== data) begin
                nfail++;
                $display("FAIL %s: got kind=%0d idx=%0d data=%h, expected kind=%0d idx=%0d data=%h",
                         nm, kind, idx, data, e.kind, e.idx, e.data);
            end
        end
    endtask

    task automatic drain(input int budget, input string nm);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s: %0d events outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_grant(input int i, input int budget);
        int c = 0;
        while (!cpu.m_grant[i] && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("grant_wait", 32'(cpu.m_grant[i]), 32'h1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_cpu_ctl"}, 32'({cpu.m_grant, cpu.m_wready, cpu.m_rvalid, cpu.m_done}), 32'h0);
        chk({nm, "_rdata"},   cpu.m_rdata, 32'h0);
        chk({nm, "_mem_ctl"}, 32'({mem.mem_req, mem.mem_we, mem.mem_wvalid, mem.mem_len}), 32'h0);
        chk({nm, "_mem_addr"}, mem.mem_addr, 32'h0);
        chk({nm, "_mem_wdata"}, mem.mem_wdata, 32'h0);
        chk({nm, "_len_err"}, 32'(len_err), 32'h0);
        chk({nm, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    // Monitor: every DUT-presented event must match the head of the scoreboard queue.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (|cpu.m_grant) check_ev(EV_GNT, int'(cpu.m_grant), 32'h0, "grant");
                if (mem.mem_req && mem.mem_ack)
                    check_ev(EV_CMD, int'(mem.mem_we) * 256 + int'(mem.mem_len), mem.mem_addr, "cmd");
                if (|cpu.m_rvalid) check_ev(EV_RD, int'(cpu.m_rvalid), cpu.m_rdata, "rbeat");
                if (mem.mem_wvalid && mem.mem_wready)
                    check_ev(EV_WR, int'(cpu.m_wready), mem.mem_wdata, "wbeat");
                if (|cpu.m_done) check_ev(EV_DONE, int'(cpu.m_done), 32'h0, "done");
            end
        end
    end

    // Downstream memory model: delayed ack, read data = addr + 4*beat, optional early rlast.
    initial begin : mem_model
        logic [31:0] a;
        logic        w;
        int          l, last, nb, k;
        mem.mem_ack = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rlast = 1'b0;
        mem.mem_rdata = '0; mem.mem_wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst && mem.mem_req) begin
                a = mem.mem_addr; w = mem.mem_we; l = int'(mem.mem_len);
                for (int d = 0; d < ack_delay; d++) begin
                    @(negedge clk);
                    chk("ack_wait_req", 32'(mem.mem_req), 32'h1);
                    chk("ack_wait_addr", mem.mem_addr, a);
                    chk("ack_wait_nobeat", 32'({cpu.m_rvalid, cpu.m_wready, mem.mem_wvalid}), 32'h0);
                    @(posedge clk); #1;
                end
                mem.mem_ack = 1'b1;
                @(posedge clk); #1;
                mem.mem_ack = 1'b0;
                last = (rlast_at >= 0 && rlast_at < l) ? rlast_at : l;
                if (!w) begin
                    for (int b = 0; b <= last && !rst; b++) begin
                        mem.mem_rvalid = 1'b1;
                        mem.mem_rdata  = a + 32'(4 * b);
                        mem.mem_rlast  = (b == last);
                        @(posedge clk); #1;
                    end
                    mem.mem_rvalid = 1'b0; mem.mem_rlast = 1'b0; mem.mem_rdata = '0;
                end else begin
                    nb = 0; k = 0;
                    while (nb <= l && k < 200 && !rst) begin
                        mem.mem_wready = wr_toggle ? (k % 2 == 0) : 1'b1;
                        @(negedge clk);
                        if (mem.mem_wvalid && mem.mem_wready) nb++;
                        @(posedge clk); #1;
                        k++;
                    end
                    mem.mem_wready = 1'b0;
                end
            end
        end
    end

    // Requester write-data driver: advance data after each accepted beat.
    initial begin : wr_drv
        logic [2:0] hs;
        forever begin
            @(negedge clk);
            hs = cpu.m_wready & cpu.m_wvalid;
            if (|hs) begin
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++) begin
                    if (hs[i]) begin
                        wbeat[i]++;
                        cpu.m_wdata[i] = wd(i, wbeat[i]);
                        if (wbeat[i] > int'(cpu.m_len[i])) cpu.m_wvalid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Requesters release m_req once granted unless told to keep it held.
    initial begin : req_drv
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (cpu.m_grant[i] && auto_drop[i]) cpu.m_req[i] = 1'b0;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb, c;
        cpu.m_req = '0; cpu.m_we = '0; cpu.m_addr = '0; cpu.m_len = '0;
        cpu.m_wdata = '0; cpu.m_wvalid = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");

        // three reads of 8 beats, served 0,1,2
        for (int i = 0; i < 3; i++) begin
            cpu.m_addr[i] = 32'h1000_0000 + 32'(i * 32'h100);
            cpu.m_len[i]  = 4'd7;
            push_burst(i, 1'b0, cpu.m_addr[i], 7, 8, 1'b1);
        end
        cpu.m_req = 3'b111;
        drain(200, "rr_reads");
        chk("len_err_rr", 32'(len_err), 32'h0);

        // requester 1 write, downstream wready toggling
        wr_toggle = 1'b1;
        cpu.m_we[1] = 1'b1; cpu.m_addr[1] = 32'h1fc0_0040; cpu.m_len[1] = 4'd3;
        wbeat[1] = 0; cpu.m_wdata[1] = wd(1, 0); cpu.m_wvalid[1] = 1'b1;
        push_burst(1, 1'b1, 32'h1fc0_0040, 3, 4, 1'b1);
        cpu.m_req[1] = 1'b1;
        drain(100, "write_toggle");
        wr_toggle = 1'b0;
        cpu.m_we[1] = 1'b0;

        // requester 0 held; requester 2 arriving mid-burst must win next
        cpu.m_len[0] = 4'd1; cpu.m_len[2] = 4'd1;
        push_burst(0, 1'b0, cpu.m_addr[0], 1, 2, 1'b1);
        push_burst(2, 1'b0, cpu.m_addr[2], 1, 2, 1'b1);
        push_burst(0, 1'b0, cpu.m_addr[0], 1, 2, 1'b1);
        auto_drop[0] = 1'b0;
        cpu.m_req[0] = 1'b1;
        wait_grant(0, 20);
        @(negedge clk);
        cpu.m_req[2] = 1'b1;
        wait_grant(2, 50);
        auto_drop[0] = 1'b1;
        drain(100, "held_req");
        chk("len_err_clean", 32'(len_err), 32'h0);

        // early rlast: len=3, rlast on beat 2
        rlast_at = 2;
        cpu.m_addr[0] = 32'h0000_4000; cpu.m_len[0] = 4'd3;
        push_burst(0, 1'b0, 32'h0000_4000, 3, 3, 1'b1);
        cpu.m_req[0] = 1'b1;
        drain(100, "early_rlast");
        chk("len_err_set", 32'(len_err), 32'h1);
        chk("early_rlast_idle", 32'(dut.state), 32'(IDLE));
        chk("early_rlast_memreq", 32'(mem.mem_req), 32'h0);
        rlast_at = -1;

        // reset during beat 3 of an 8-beat read
        cpu.m_addr[1] = 32'h0000_5000; cpu.m_len[1] = 4'd7;
        push_burst(1, 1'b0, 32'h0000_5000, 7, 4, 1'b0);
        cpu.m_req[1] = 1'b1;
        nb = 0; c = 0;
        while (nb < 4 && c < 100) begin
            @(negedge clk);
            if (cpu.m_rvalid[1]) nb++;
            c++;
        end
        chk("beat3_reached", 32'(nb), 32'd4);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_burst_reset");
        chk("reset_queue", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        rst = 1'b0;

        // after reset requester 0 wins first; slow ack; len 0 read, len 15 read, len 0 write
        ack_delay = 5;
        cpu.m_we = 3'b100;
        cpu.m_addr[0] = 32'h0000_1000; cpu.m_len[0] = 4'd0;
        cpu.m_addr[1] = 32'h0000_2000; cpu.m_len[1] = 4'd15;
        cpu.m_addr[2] = 32'h0000_3000; cpu.m_len[2] = 4'd0;
        wbeat[2] = 0; cpu.m_wdata[2] = wd(2, 0); cpu.m_wvalid[2] = 1'b1;
        push_burst(0, 1'b0, 32'h0000_1000, 0, 1, 1'b1);
        push_burst(1, 1'b0, 32'h0000_2000, 15, 16, 1'b1);
        push_burst(2, 1'b1, 32'h0000_3000, 0, 1, 1'b1);
        cpu.m_req = 3'b111;
        drain(300, "post_reset_bounds");
        chk("len_err_bounds", 32'(len_err), 32'h0);
        chk("final_idle", 32'(dut.state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
